synapse_dispatcher: RTL and testbench

SYNAPSE_DISPATCHER -- requirements
Module: synapse_dispatcher

---
 rtl/synapse_dispatcher.sv | 193 +++++++++++++++++++
 tb/tb_synapse_dispatcher.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_dispatcher.sv
// -----------------------------------------------------------------------------
// synapse_dispatcher
//
// Purpose:
//   Accepts spike events (firing neuron IDs) into a small FIFO and expands each
//   spike into its list of synaptic events.  Each source owns FANOUT_MAX
//   consecutive words of an external synapse table; the list ends at the first
//   entry whose valid bit is clear, or after FANOUT_MAX entries.  One source is
//   fully dispatched before the next spike is taken from the FIFO.
//
// Ports:
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   spike_in_neuron_id/_valid   spike input, valid/ready handshake
//   spike_in_ready
//   tbl_rd_en, tbl_addr         table read request; address = {src[SRC_BITS-1:0], k}
//   tbl_rd_data                 {valid, target_id[15:0], weight[7:0]}, one cycle
//                               after tbl_rd_en
//   syn_src_id/_target_id       synaptic event output, valid/ready handshake
//   syn_weight/_valid, syn_ready
//   busy                        dispatcher FSM not idle
//   fifo_count                  spike FIFO occupancy
//   fsm_state                   current FSM state (IDLE=0, FETCH=1, WAIT=2, EMIT=3)
//   stat_clear, stat_spikes_in, optional saturating handshake counters,
//   stat_events_out             present only when DISPATCH_STATS_EN is defined
//
// Handshake semantics (both channels): a transfer happens on a rising edge where
// valid and ready are both high; the producer keeps valid and its payload
// stable until that edge, and ready may be driven from any state.
//
// Optional feature macro: DISPATCH_STATS_EN (undefined in the default build).
// -----------------------------------------------------------------------------
module synapse_dispatcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int FANOUT_MAX = 4,
   parameter int SRC_BITS   = 6,
   localparam int K_W       = $clog2(FANOUT_MAX),
   localparam int ADDR_W    = SRC_BITS + K_W,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       spike_in_neuron_id,
   input  logic              spike_in_valid,
   output logic              spike_in_ready,
   output logic              tbl_rd_en,
   output logic [ADDR_W-1:0] tbl_addr,
   input  logic [24:0]       tbl_rd_data,
   output logic [15:0]       syn_src_id,
   output logic [15:0]       syn_target_id,
   output logic [7:0]        syn_weight,
   output logic              syn_valid,
   input  logic              syn_ready,
   output logic              busy,
   output logic [1:0]        fsm_state,
`ifdef DISPATCH_STATS_EN
   input  logic              stat_clear,
   output logic [15:0]       stat_spikes_in,
   output logic [15:0]       stat_events_out,
`endif
   output logic [CNT_W-1:0]  fifo_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_EMIT  = 2'd3;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [K_W-1:0]   K_LAST  = K_W'(FANOUT_MAX - 1);

   // ---------------------------------------------------------------- FIFO
   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   logic [1:0]       state;
   logic [15:0]      src;
   logic [K_W-1:0]   k;

   assign spike_in_ready = (count < DEPTH_C);
   assign push           = spike_in_valid && spike_in_ready;
   // The FSM takes the head only while idle, so a whole source list is
   // dispatched before the next spike is looked at.
   assign pop            = (state == S_IDLE) && (count != '0);
   assign fifo_count     = count;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= spike_in_neuron_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   assign tbl_rd_en = (state == S_FETCH);
   assign tbl_addr  = {src[SRC_BITS-1:0], k};
   assign busy      = (state != S_IDLE);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         src           <= '0;
         k             <= '0;
         syn_valid     <= 1'b0;
         syn_src_id    <= '0;
         syn_target_id <= '0;
         syn_weight    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  src   <= fifo_mem[rd_ptr];
                  k     <= '0;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               // Table word arrives this cycle; a clear valid bit ends the list.
               if (tbl_rd_data[24]) begin
                  syn_src_id    <= src;
                  syn_target_id <= tbl_rd_data[23:8];
                  syn_weight    <= tbl_rd_data[7:0];
                  syn_valid     <= 1'b1;
                  state         <= S_EMIT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_EMIT: begin
               // Outputs are registers untouched here until the handshake.
               if (syn_ready) begin
                  syn_valid <= 1'b0;
                  if (k == K_LAST) begin
                     state <= S_IDLE;
                  end else begin
                     k     <= k + K_W'(1);
                     state <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- stats
`ifdef DISPATCH_STATS_EN
   logic syn_hs;
   assign syn_hs = syn_valid && syn_ready;

   always_ff @(posedge clk) begin
      if (rst || stat_clear) begin
         // Clear wins over any increment in the same cycle.
         stat_spikes_in  <= '0;
         stat_events_out <= '0;
      end else begin
         if (push && (stat_spikes_in != 16'hFFFF)) begin
            stat_spikes_in <= stat_spikes_in + 16'd1;
         end
         if (syn_hs && (stat_events_out != 16'hFFFF)) begin
            stat_events_out <= stat_events_out + 16'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_synapse_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_synapse_dispatcher
//
// Purpose: self-checking bench for synapse_dispatcher.  A table memory answers
// read strobes one cycle later; a behavioural model expands every accepted spike
// into its expected event list and a per-cycle monitor compares every output
// handshake and hold period against it.  Directed sequences pin timing and
// status values with hand-computed literals.
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_synapse_dispatcher;

   localparam int FIFO_DEPTH = 4;
   localparam int FANOUT_MAX = 4;
   localparam int SRC_BITS   = 6;
   localparam int ADDR_W     = SRC_BITS + $clog2(FANOUT_MAX);
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   // ---------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [15:0]       spike_in_neuron_id;
   logic              spike_in_valid;
   logic              spike_in_ready;
   logic              tbl_rd_en;
   logic [ADDR_W-1:0] tbl_addr;
   logic [24:0]       tbl_rd_data = '0;
   logic [15:0]       syn_src_id;
   logic [15:0]       syn_target_id;
   logic [7:0]        syn_weight;
   logic              syn_valid;
   logic              syn_ready;
   logic              busy;
   logic [1:0]        fsm_state;
   logic [CNT_W-1:0]  fifo_count;
`ifdef DISPATCH_STATS_EN
   logic              stat_clear;
   logic [15:0]       stat_spikes_in;
   logic [15:0]       stat_events_out;
`endif

   synapse_dispatcher #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .FANOUT_MAX(FANOUT_MAX),
      .SRC_BITS  (SRC_BITS)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .spike_in_neuron_id(spike_in_neuron_id),
      .spike_in_valid    (spike_in_valid),
      .spike_in_ready    (spike_in_ready),
      .tbl_rd_en         (tbl_rd_en),
      .tbl_addr          (tbl_addr),
      .tbl_rd_data       (tbl_rd_data),
      .syn_src_id        (syn_src_id),
      .syn_target_id     (syn_target_id),
      .syn_weight        (syn_weight),
      .syn_valid         (syn_valid),
      .syn_ready         (syn_ready),
      .busy              (busy),
      .fsm_state         (fsm_state),
`ifdef DISPATCH_STATS_EN
      .stat_clear        (stat_clear),
      .stat_spikes_in    (stat_spikes_in),
      .stat_events_out   (stat_events_out),
`endif
      .fifo_count        (fifo_count)
   );

   // ---------------------------------------------------------- table memory
   logic [24:0] tbl_mem [0:(1<<ADDR_W)-1];

   always @(posedge clk) begin
      if (tbl_rd_en) tbl_rd_data <= tbl_mem[tbl_addr];
   end

   // ---------------------------------------------------------- scoreboard
   logic [39:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_events = 0;
   int          n_rd     = 0;
   int          n_valid_cycles = 0;
   logic        hold_prev = 1'b0;
   logic [39:0] prev_bundle = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Model: a spike expands into the table words of its source (ID modulo
   // 2^SRC_BITS), in index order, up to the first invalid word or FANOUT_MAX.
   task automatic model_accept(input logic [15:0] id);
      logic [24:0] e;
      int base;
      base = (int'(id) % (1 << SRC_BITS)) * FANOUT_MAX;
      for (int i = 0; i < FANOUT_MAX; i++) begin
         e = tbl_mem[base + i];
         if (!e[24]) break;
         exp_q.push_back({id, e[23:8], e[7:0]});
      end
   endtask

   // Called once per cycle at the falling edge, where inputs and outputs are
   // settled for the coming rising edge.
   task automatic monitor();
      logic [39:0] got;
      logic [39:0] exp;
      got = {syn_src_id, syn_target_id, syn_weight};
      if (tbl_rd_en) n_rd++;
      if (syn_valid) n_valid_cycles++;
      if (rst) begin
         exp_q.delete();
         hold_prev = 1'b0;
         return;
      end
      if (hold_prev) begin
         check("hold_valid", syn_valid, 1'b1);
         check("hold_payload", got, prev_bundle);
      end
      if (spike_in_valid && spike_in_ready) model_accept(spike_in_neuron_id);
      if (syn_valid && syn_ready) begin
         n_events++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event actual=%0h required=none at %0t", got, $time);
         end else begin
            exp = exp_q.pop_front();
            check("event", got, exp);
         end
      end
      hold_prev   = syn_valid && !syn_ready;
      prev_bundle = got;
   endtask

   // ---------------------------------------------------------- driver tasks
   // One clock: monitor at the falling edge, then return 1 ns after the rising
   // edge so the caller can check post-edge state and drive new inputs.
   task automatic cycle();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send_spike(input logic [15:0] id);
      logic acc;
      acc = 1'b0;
      spike_in_valid     = 1'b1;
      spike_in_neuron_id = id;
      for (int i = 0; i < 200; i++) begin
         acc = spike_in_ready;
         cycle();
         if (acc) break;
      end
      spike_in_valid = 1'b0;
      if (!acc) check("spike_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy && !syn_valid && fifo_count == 0) begin
            done = 1'b1;
            break;
         end
         cycle();
      end
      if (!done) check("idle_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_valid(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (syn_valid) begin
            done = 1'b1;
            break;
         end
         cycle();
      end
      if (!done) check("valid_timeout", 1'b0, 1'b1);
   endtask

   // ---------------------------------------------------------- main sequence
   initial begin
      int ev0;
      int rd0;
      int vc0;

      for (int i = 0; i < (1 << ADDR_W); i++) tbl_mem[i] = '0;
      // src 5: two events then end of list
      tbl_mem[20] = {1'b1, 16'h0010, 8'h03};
      tbl_mem[21] = {1'b1, 16'h0011, 8'hFE};
      // src 7: full list, includes a zero weight
      tbl_mem[28] = {1'b1, 16'h0070, 8'h00};
      tbl_mem[29] = {1'b1, 16'h0071, 8'h7F};
      tbl_mem[30] = {1'b1, 16'h0072, 8'h80};
      tbl_mem[31] = {1'b1, 16'h0073, 8'h01};
      // src 9: empty list (entry 36 left invalid)

      rst                = 1'b1;
      spike_in_valid     = 1'b0;
      spike_in_neuron_id = '0;
      syn_ready          = 1'b0;
`ifdef DISPATCH_STATS_EN
      stat_clear         = 1'b0;
`endif
      repeat (3) cycle();
      rst = 1'b0;

      // ---- reset state
      check("rst_syn_valid", syn_valid, 1'b0);
      check("rst_tbl_rd_en", tbl_rd_en, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_ready", spike_in_ready, 1'b1);
      check("rst_payload", {syn_src_id, syn_target_id, syn_weight}, 40'h0);
`ifdef DISPATCH_STATS_EN
      check("rst_stat_spikes", stat_spikes_in, 0);
      check("rst_stat_events", stat_events_out, 0);
`endif

      // ---- src 5 latency and content
      syn_ready = 1'b1;
      ev0 = n_events;
      send_spike(16'h0005);                 // accepted at edge N
      check("l_fifo_n", fifo_count, 1);
      check("l_busy_n", busy, 1'b0);
      cycle();                              // N+1: FETCH k=0
      check("l_busy_n1", busy, 1'b1);
      check("l_rd_n1", tbl_rd_en, 1'b1);
      check("l_addr_n1", tbl_addr, 20);
      check("l_fifo_n1", fifo_count, 0);
      cycle();                              // N+2: WAIT
      check("l_rd_n2", tbl_rd_en, 1'b0);
      check("l_valid_n2", syn_valid, 1'b0);
      cycle();                              // N+3: first event
      check("l_valid_n3", syn_valid, 1'b1);
      check("l_ev0", {syn_src_id, syn_target_id, syn_weight}, {16'h0005, 16'h0010, 8'h03});
      cycle();                              // N+4: handshake done, FETCH k=1
      check("l_valid_n4", syn_valid, 1'b0);
      check("l_addr_n4", tbl_addr, 21);
      cycle();
      cycle();                              // N+6: second event
      check("l_valid_n6", syn_valid, 1'b1);
      check("l_ev1", {syn_src_id, syn_target_id, syn_weight}, {16'h0005, 16'h0011, 8'hFE});
      repeat (3) cycle();                   // N+7 hs, N+8 WAIT on invalid, N+9 IDLE
      check("l_busy_n9", busy, 1'b0);
      check("l_events", n_events - ev0, 2);
      check("l_q_empty", exp_q.size(), 0);
`ifdef DISPATCH_STATS_EN
      check("stat_spikes_1", stat_spikes_in, 1);
      check("stat_events_2", stat_events_out, 2);
`endif

      // ---- source index taken modulo 2^SRC_BITS, full ID on output
      ev0 = n_events;
      send_spike(16'h0045);
      wait_valid(10);
      check("mod_src", syn_src_id, 16'h0045);
      check("mod_tgt", syn_target_id, 16'h0010);
      wait_idle(50);
      check("mod_events", n_events - ev0, 2);

      // ---- src 7 with back-pressure on the first event
      syn_ready = 1'b0;
      ev0 = n_events;
      send_spike(16'h0007);
      wait_valid(10);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_valid", syn_valid, 1'b1);
         check("bp_payload", {syn_src_id, syn_target_id, syn_weight}, {16'h0007, 16'h0070, 8'h00});
      end
      syn_ready = 1'b1;
      wait_idle(50);
      check("bp_events", n_events - ev0, 4);
      check("bp_q_empty", exp_q.size(), 0);

      // ---- src 9: empty list
      ev0 = n_events;
      rd0 = n_rd;
      vc0 = n_valid_cycles;
      send_spike(16'h0009);                 // accepted at edge E
      cycle();                              // E+1: FETCH
      check("e_busy_1", busy, 1'b1);
      check("e_rd_1", tbl_rd_en, 1'b1);
      cycle();                              // E+2: WAIT
      check("e_busy_2", busy, 1'b1);
      check("e_rd_2", tbl_rd_en, 1'b0);
      cycle();                              // E+3: IDLE
      check("e_busy_3", busy, 1'b0);
      repeat (3) cycle();
      check("e_rd_pulses", n_rd - rd0, 1);
      check("e_valid_cycles", n_valid_cycles - vc0, 0);
      check("e_events", n_events - ev0, 0);

      // ---- FIFO fill under back-pressure, order preserved
      syn_ready = 1'b0;
      ev0 = n_events;
      send_spike(16'h0007);
      send_spike(16'h0005);
      check("f_push_pop_count", fifo_count, 1);
      send_spike(16'h0009);
      send_spike(16'h0045);
      send_spike(16'h01C7);
      check("f_count_full", fifo_count, 4);
      check("f_ready_full", spike_in_ready, 1'b0);
      spike_in_valid     = 1'b1;
      spike_in_neuron_id = 16'h0005;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("f_ready_low", spike_in_ready, 1'b0);
         check("f_count_held", fifo_count, 4);
      end
      spike_in_valid = 1'b0;
      syn_ready = 1'b1;
      wait_idle(300);
      check("f_events", n_events - ev0, 12);
      check("f_q_empty", exp_q.size(), 0);

      // ---- reset in EMIT with two spikes queued
      syn_ready = 1'b0;
      ev0 = n_events;
      send_spike(16'h0005);
      send_spike(16'h0007);
      send_spike(16'h0009);
      wait_valid(10);
      check("r_queued", fifo_count, 2);
      check("r_busy_pre", busy, 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("r_valid", syn_valid, 1'b0);
      check("r_fifo", fifo_count, 0);
      check("r_busy", busy, 1'b0);
      check("r_ready", spike_in_ready, 1'b1);
      check("r_payload", {syn_src_id, syn_target_id, syn_weight}, 40'h0);
      syn_ready = 1'b1;
      repeat (20) cycle();
      check("r_no_events", n_events - ev0, 0);
      check("r_still_idle", busy, 1'b0);
      send_spike(16'h0045);
      wait_idle(50);
      check("r_new_events", n_events - ev0, 2);

`ifdef DISPATCH_STATS_EN
      check("stat_after_rst_spikes", stat_spikes_in, 1);
      check("stat_after_rst_events", stat_events_out, 2);
      stat_clear = 1'b1;
      send_spike(16'h0009);
      stat_clear = 1'b0;
      check("stat_clear_spikes", stat_spikes_in, 0);
      check("stat_clear_events", stat_events_out, 0);
      wait_idle(50);
      check("stat_post_spikes", stat_spikes_in, 0);
      check("stat_post_events", stat_events_out, 0);
`endif

      repeat (2) cycle();
      check("final_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
